fb_writer: RTL and testbench

FB_WRITER -- requirements
Module: fb_writer

---
 rtl/fb_writer_if.sv | 25 ++
 rtl/fb_writer.sv | 130 +++++++++++++
 tb/tb_fb_writer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fb_writer_if.sv
// Bundle of the pixel stream, frame-buffer write port and status signals of fb_writer.
// Handshake: a pixel transfers on a rising clk edge where s_valid and s_ready are both 1.
interface fb_writer_if;
    logic        start;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [17:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        busy;
    logic        done;
    logic [15:0] checksum;
    logic [1:0]  dbg_state;

    modport slave (
        input  start, s_data, s_valid,
        output s_ready, wr_addr, wr_data, wr_en, busy, done, checksum, dbg_state
    );

    modport master (
        output start, s_data, s_valid,
        input  s_ready, wr_addr, wr_data, wr_en, busy, done, checksum, dbg_state
    );
endinterface

// File: rtl/fb_writer.sv
// Loads an N x N raster-order grayscale stream into a column-major frame buffer.
// Optional byte checksum enabled by defining FB_WRITER_CHECKSUM_EN.
module fb_writer #(
    parameter int N = 400
) (
    input  logic     clk,
    input  logic     rst_n,
    fb_writer_if.slave bus
);
    localparam int            CW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST   = CW'(N - 1);
    localparam logic [17:0]   STRIDE = 18'(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic [17:0]   acc_q, acc_d;
    logic [17:0]   wr_addr_q;
    logic [7:0]    wr_data_q;
    logic          wr_en_q;

    logic s_ready, busy, done;
    logic accept, start_load, last_pix;

    assign accept     = bus.s_valid && (state_q == LOAD);
    assign start_load = bus.start && (state_q == IDLE);
    assign last_pix   = accept && (col_q == LAST) && (row_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = LOAD;
            LOAD:    if (last_pix) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            LOAD:    begin s_ready = 1'b1; busy = 1'b1; end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // acc tracks col*N + row of the pixel at the head of the stream.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        acc_d = acc_q;
        if (start_load) begin
            col_d = '0;
            row_d = '0;
            acc_d = '0;
        end else if (accept) begin
            if (col_q == LAST) begin
                col_d = '0;
                row_d = last_pix ? '0 : row_q + 1'b1;
                acc_d = 18'(row_q) + 18'd1;
            end else begin
                col_d = col_q + 1'b1;
                acc_d = acc_q + STRIDE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q     <= '0;
            row_q     <= '0;
            acc_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            acc_q   <= acc_d;
            wr_en_q <= accept;
            if (accept) begin
                wr_addr_q <= acc_q;
                wr_data_q <= bus.s_data;
            end
        end
    end

`ifdef FB_WRITER_CHECKSUM_EN
    logic [15:0] csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (start_load) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= csum_q + {8'h00, bus.s_data};
        end
    end

    assign bus.checksum = csum_q;
`else
    assign bus.checksum = 16'h0000;
`endif

    assign bus.s_ready   = s_ready;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer at N = 4: vector table for a full frame plus hand sequences.
module tb_fb_writer;
    localparam int N = 4;

    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  data;
        logic [29:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [25:0] exp_q[$];
    vec_t vecs[19];

    fb_writer_if bus();

    fb_writer #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    wire [29:0] obs = {bus.s_ready, bus.busy, bus.done, bus.wr_en, bus.wr_addr, bus.wr_data};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [29:0] pk(input logic r, input logic b, input logic d,
                                       input logic e, input int a, input int dat);
        return {r, b, d, e, 18'(a), 8'(dat)};
    endfunction

    function automatic int col_major(input int k);
        return (k % N) * N + (k / N);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic v, input logic [7:0] d);
        bus.start   = st;
        bus.s_valid = v;
        bus.s_data  = d;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Score one cycle after a pixel was offered and accepted.
    task automatic score_write(input string name);
        logic [25:0] e;
        check({name, "_wr_en"}, 32'(bus.wr_en), 32'd1);
        if (bus.wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check({name, "_unexpected"}, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check({name, "_addr_data"}, 32'({bus.wr_addr, bus.wr_data}), 32'(e));
            end
        end
    endtask

    task automatic send_pixel(input logic st, input logic [7:0] d, input int k);
        exp_q.push_back({18'(col_major(k)), d});
        drive(st, 1'b1, d);
        step();
        score_write($sformatf("px%0d", k));
        check($sformatf("px%0d_done", k), 32'(bus.done), (k == N * N - 1) ? 32'd1 : 32'd0);
    endtask

    task automatic start_frame();
        drive(1'b1, 1'b0, 8'h00);
        step();
        check("start_busy", 32'(bus.busy), 32'd1);
    endtask

    initial begin
        logic [15:0] exp_cs_ramp;
        logic [15:0] exp_cs_ff;
        checks = 0;
        errors = 0;
`ifdef FB_WRITER_CHECKSUM_EN
        exp_cs_ramp = 16'h0078;
        exp_cs_ff   = 16'h0FF0;
`else
        exp_cs_ramp = 16'h0000;
        exp_cs_ff   = 16'h0000;
`endif

        vecs[0] = '{1'b1, 1'b0, 8'h00, pk(1, 1, 0, 0, 0, 0)};
        for (int k = 0; k < N * N; k++) begin
            vecs[k + 1] = '{1'b0, 1'b1, 8'(k),
                            (k == N * N - 1) ? pk(0, 0, 1, 1, col_major(k), k)
                                             : pk(1, 1, 0, 1, col_major(k), k)};
        end
        vecs[17] = '{1'b0, 1'b0, 8'h00, pk(0, 0, 0, 0, 15, 15)};
        vecs[18] = '{1'b0, 1'b1, 8'hAA, pk(0, 0, 0, 0, 15, 15)};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        step();
        step();
        check("reset_outputs", 32'(obs), 32'd0);
        check("reset_checksum", 32'(bus.checksum), 32'd0);
        check("reset_state", 32'(bus.dbg_state), 32'd0);
        rst_n = 1'b1;

        // s_valid with no start must be ignored.
        drive(1'b0, 1'b1, 8'h55);
        step();
        step();
        check("idle_valid", 32'(obs), 32'd0);

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].start, vecs[i].valid, vecs[i].data);
            step();
            check($sformatf("vec%0d", i), 32'(obs), 32'(vecs[i].exp));
        end
        check("ramp_checksum", 32'(bus.checksum), 32'(exp_cs_ramp));

        // Stalled stream: a bubble after every pixel.
        start_frame();
        for (int k = 0; k < N * N; k++) begin
            send_pixel(1'b0, 8'(k), k);
            if (k == N * N - 1) check("stall_cs_done", 32'(bus.checksum), 32'(exp_cs_ramp));
            drive(1'b0, 1'b0, 8'hEE);
            step();
            check($sformatf("stall%0d_nowr", k), 32'({bus.wr_en, bus.wr_addr, bus.wr_data}),
                  32'({1'b0, 18'(col_major(k)), 8'(k)}));
        end
        check("stall_q_empty", 32'(exp_q.size()), 32'd0);

        // start during LOAD must not disturb the counters.
        start_frame();
        for (int k = 0; k < N * N; k++) begin
            send_pixel(k == 7, 8'hFF, k);
        end
        check("ff_checksum_done", 32'(bus.checksum), 32'(exp_cs_ff));
        drive(1'b0, 1'b0, 8'h00);
        step();
        step();
        check("ff_idle", 32'({bus.busy, bus.wr_en}), 32'd0);
        check("ff_checksum_hold", 32'(bus.checksum), 32'(exp_cs_ff));
        check("ff_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a frame.
        start_frame();
        for (int k = 0; k < 6; k++) begin
            send_pixel(1'b0, 8'(8'h10 + k), k);
        end
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", 32'(obs), 32'd0);
        check("midreset_checksum", 32'(bus.checksum), 32'd0);
        step();
        check("midreset_held", 32'(obs), 32'd0);
        rst_n = 1'b1;
        step();
        check("postreset_nowrite", 32'(obs), 32'd0);
        start_frame();
        send_pixel(1'b0, 8'h5A, 0);
        check("postreset_q_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
